// File: rtl/lcd_ctrl.sv
// HD44780-style 16x2 LCD timing engine: power-up init sequence, then one timed
// setup/EN-pulse/hold/execute cycle per software strobe, with a one-entry pending slot.
module lcd_ctrl #(
  parameter int POWER_ON_CYC = 750000,
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 24,
  parameter int HOLD_CYC     = 4,
  parameter int EXEC_CYC     = 2000,
  parameter int CLEAR_CYC    = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int MAX_CYC = (POWER_ON_CYC > CLEAR_CYC) ? POWER_ON_CYC : CLEAR_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_IDLE     = 3'd5;

  localparam logic [2:0] LAST_INIT = 3'd4;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h38;
      3'd2:    init_cmd = 8'h0C;
      3'd3:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          init_q, init_d;
  logic          act_rs_q, act_rs_d;
  logic [7:0]    act_data_q, act_data_d;
  logic          pend_full_q, pend_full_d;
  logic          pend_rs_q, pend_rs_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          prev_strobe_q, prev_strobe_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          en_q, en_d;
  logic          on_q, on_d;

  logic req;
  logic take_direct;
  logic cnt_done;
  logic is_clear;
  logic lcd_word_unused;

  assign lcd_word_unused = ^{i_lcd_word[30:11], i_lcd_word[8]};
  assign req      = i_lcd_word[10] & ~prev_strobe_q;
  assign cnt_done = (cnt_q <= CW'(1));
  // Clear/home commands need the long execute time.
  assign is_clear = ~act_rs_q && (act_data_q == 8'h01 || act_data_q == 8'h02 || act_data_q == 8'h03);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_idx_d    = init_idx_q;
    init_d        = init_q;
    act_rs_d      = act_rs_q;
    act_data_d    = act_data_q;
    pend_full_d   = pend_full_q;
    pend_rs_d     = pend_rs_q;
    pend_data_d   = pend_data_q;
    overrun_d     = overrun_q;
    prev_strobe_d = i_lcd_word[10];
    on_d          = i_lcd_word[31];
    take_direct   = 1'b0;

    case (state_q)
      S_PWR_WAIT: begin
        // A cleared counter marks the first cycle after reset.
        if (cnt_q == '0) begin
          cnt_d = CW'(POWER_ON_CYC - 1);
        end else if (cnt_q == CW'(1)) begin
          state_d    = S_SETUP;
          cnt_d      = CW'(SETUP_CYC);
          init_d     = 1'b1;
          init_idx_d = 3'd0;
          act_rs_d   = 1'b0;
          act_data_d = init_cmd(3'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          state_d = S_PULSE;
          cnt_d   = CW'(PULSE_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_done) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_d = S_WAIT;
          cnt_d   = is_clear ? CW'(CLEAR_CYC) : CW'(EXEC_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (init_q && init_idx_q != LAST_INIT) begin
          state_d    = S_SETUP;
          cnt_d      = CW'(SETUP_CYC);
          init_idx_d = init_idx_q + 3'd1;
          act_rs_d   = 1'b0;
          act_data_d = init_cmd(init_idx_q + 3'd1);
        end else begin
          init_d = 1'b0;
          if (pend_full_q) begin
            state_d     = S_SETUP;
            cnt_d       = CW'(SETUP_CYC);
            act_rs_d    = pend_rs_q;
            act_data_d  = pend_data_q;
            pend_full_d = 1'b0;
          end else if (req) begin
            state_d     = S_SETUP;
            cnt_d       = CW'(SETUP_CYC);
            act_rs_d    = i_lcd_word[9];
            act_data_d  = i_lcd_word[7:0];
            take_direct = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (req) begin
          state_d     = S_SETUP;
          cnt_d       = CW'(SETUP_CYC);
          act_rs_d    = i_lcd_word[9];
          act_data_d  = i_lcd_word[7:0];
          take_direct = 1'b1;
        end
      end
    endcase

    // Uses pend_full_d so a slot vacated this cycle can be refilled without overrun.
    if (req && !take_direct) begin
      if (pend_full_d) begin
        overrun_d = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_rs_d   = i_lcd_word[9];
        pend_data_d = i_lcd_word[7:0];
      end
    end
  end

  assign busy_d = (state_d != S_IDLE) | pend_full_d;
  assign en_d   = (state_d == S_PULSE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_PWR_WAIT;
      cnt_q         <= '0;
      init_idx_q    <= 3'd0;
      init_q        <= 1'b0;
      act_rs_q      <= 1'b0;
      act_data_q    <= 8'h00;
      pend_full_q   <= 1'b0;
      pend_rs_q     <= 1'b0;
      pend_data_q   <= 8'h00;
      prev_strobe_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b1;
      en_q          <= 1'b0;
      on_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_idx_q    <= init_idx_d;
      init_q        <= init_d;
      act_rs_q      <= act_rs_d;
      act_data_q    <= act_data_d;
      pend_full_q   <= pend_full_d;
      pend_rs_q     <= pend_rs_d;
      pend_data_q   <= pend_data_d;
      prev_strobe_q <= prev_strobe_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      en_q          <= en_d;
      on_q          <= on_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = act_rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = act_data_q;

endmodule
